// File: rtl/flp_unit_arbiter_pkg.sv
// Shared constants and types for the floating-point core arbiter.
package flp_unit_arbiter_pkg;

    localparam int FLT_W       = 32;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TAG_W   = 2;
    localparam int DEF_MAX_OUT = 8;

    localparam logic [FLT_W-1:0] FLT_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic [FLT_W-1:0] a;
        logic [FLT_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/flp_unit_arbiter_tag_fifo.sv
// In-order tag queue: remembers which requester owns each result still inside the core.
module flp_tag_fifo
    import flp_unit_arbiter_pkg::*;
#(
    parameter  int WIDTH = DEF_TAG_W,
    parameter  int DEPTH = DEF_MAX_OUT,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flp_unit_arbiter.sv
// Round-robin sharing of one pipelined FP core; results are routed home via an in-order tag queue.
module flp_unit_arbiter
    import flp_unit_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*FLT_W-1:0] req_a,
    input  logic [N_REQ*FLT_W-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [FLT_W-1:0]       resp_data,
    output logic [FLT_W-1:0]       fp_a,
    output logic [FLT_W-1:0]       fp_b,
    output logic                   fp_nd,
    input  logic                   fp_rfd,
    input  logic [FLT_W-1:0]       fp_result,
    input  logic                   fp_rdy,
    output logic                   busy,
    output logic                   err_orphan
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [TAG_W-1:0] ptr_q, ptr_d, grant_idx, tag_out;
    logic [N_REQ-1:0] valid_rot, resp_valid_q, resp_valid_d;
    logic [FLT_W-1:0] resp_data_q, resp_data_d;
    logic [CNT_W-1:0] in_flight;
    operand_t         opnd_q, opnd_d;
    logic             nd_q, err_q, err_d;
    logic             grant, pop, orphan, fifo_full, fifo_empty;

    // Rotate so bit 0 is the requester the pointer currently favours.
    assign valid_rot = N_REQ'({req_valid, req_valid} >> ptr_q);
    assign grant     = fp_rfd && !fifo_full && (|req_valid);
    assign pop       = fp_rdy && !fifo_empty;
    assign orphan    = fp_rdy && fifo_empty;

    always_comb begin
        int off;
        int sum;
        off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) off = i;
        end
        sum = int'(ptr_q) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        grant_idx = TAG_W'(sum);
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = grant && (grant_idx == TAG_W'(k));
        end
    end

    // NOTE: every next-state signal takes a default first, so no latch is inferred.
    always_comb begin
        ptr_d        = ptr_q;
        opnd_d       = opnd_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        err_d        = err_q | orphan;
        if (grant) begin
            ptr_d = (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_idx == TAG_W'(k)) begin
                    opnd_d.a = req_a[k*FLT_W +: FLT_W];
                    opnd_d.b = req_b[k*FLT_W +: FLT_W];
                end
            end
        end
        if (pop) begin
            resp_data_d = fp_result;
            for (int k = 0; k < N_REQ; k++) begin
                resp_valid_d[k] = (tag_out == TAG_W'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            opnd_q       <= '0;
            nd_q         <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= FLT_ZERO;
            err_q        <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            opnd_q       <= opnd_d;
            nd_q         <= grant;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end

    flp_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (tag_out),
        .count     (in_flight),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fp_a       = opnd_q.a;
    assign fp_b       = opnd_q.b;
    assign fp_nd      = nd_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (in_flight != '0) || (resp_valid_q != '0);
    assign err_orphan = err_q;

endmodule

// File: tb/tb_flp_unit_arbiter.sv
// Bench for flp_unit_arbiter: 6-cycle in-order multiplier model, queue-based reference, directed tests.
module tb_flp_unit_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 6;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [127:0]  req_a = '0, req_b = '0;
    logic [3:0]    req_ready, resp_valid;
    logic [31:0]   resp_data, fp_a, fp_b;
    logic          fp_nd, busy, err_orphan;
    logic          fp_rfd = 1'b1, fp_rdy = 1'b0;
    logic [31:0]   fp_result = '0;

    int n_checks = 0;
    int n_pass   = 0;

    flp_unit_arbiter #(.N_REQ(N), .TAG_W(2), .MAX_OUT(MAXO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .fp_a       (fp_a),
        .fp_b       (fp_b),
        .fp_nd      (fp_nd),
        .fp_rfd     (fp_rfd),
        .fp_result  (fp_result),
        .fp_rdy     (fp_rdy),
        .busy       (busy),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Single-precision multiply for normal operands, truncating.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            m = m >> 1;
            e++;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    // In-order core model: result appears LAT cycles after operation_nd.
    typedef struct { int due; logic [31:0] res; } core_ent_t;
    core_ent_t core_q[$];
    core_ent_t ent;
    int   cyc = 0;
    logic core_stall = 1'b0, force_rdy = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (fp_nd === 1'b1) begin
            ent.due = cyc + LAT;
            ent.res = fmul(fp_a, fp_b);
            core_q.push_back(ent);
        end
        fp_rdy = 1'b0;
        if (force_rdy) begin
            fp_rdy    = 1'b1;
            fp_result = 32'hdead_beef;
        end else if (!core_stall && core_q.size() > 0 && core_q[0].due <= cyc) begin
            fp_rdy    = 1'b1;
            fp_result = core_q[0].res;
            void'(core_q.pop_front());
        end
    end

    // Reference model: expected outputs for the next cycle from queue-level rules.
    int          mptr = 0;
    int          mtags[$];
    int          m_w, m_tag, m_idx;
    logic [3:0]  m_ready;
    logic        exp_nd = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_a = '0, exp_b = '0, exp_rd = '0;
    logic [3:0]  exp_rv = '0;

    always @(negedge clk) begin
        m_w = -1;
        if (fp_rfd && mtags.size() < MAXO) begin
            for (int i = 0; i < N; i++) begin
                m_idx = (mptr + i) % N;
                if (m_w < 0 && ((req_valid >> m_idx) & 4'b1) != 4'b0) m_w = m_idx;
            end
        end
        m_ready = (m_w >= 0) ? 4'(1 << m_w) : 4'b0;

        check("req_ready", 32'(req_ready), 32'(m_ready));
        check("fp_nd", 32'(fp_nd), 32'(exp_nd));
        check("fp_a", fp_a, exp_a);
        check("fp_b", fp_b, exp_b);
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv != 4'b0) check("resp_data", resp_data, exp_rd);
        check("busy", 32'(busy), 32'(exp_busy));
        check("err_orphan", 32'(err_orphan), 32'(exp_err));

        if (rst) begin
            mptr = 0;
            mtags.delete();
            exp_nd = 1'b0; exp_a = '0; exp_b = '0;
            exp_rv = '0; exp_rd = '0; exp_err = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_nd = 1'b0;
            exp_rv = '0;
            if (fp_rdy) begin
                if (mtags.size() > 0) begin
                    m_tag  = mtags.pop_front();
                    exp_rv = 4'(1 << m_tag);
                    exp_rd = fp_result;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (m_w >= 0) begin
                exp_nd = 1'b1;
                exp_a  = 32'(req_a >> (32 * m_w));
                exp_b  = 32'(req_b >> (32 * m_w));
                mtags.push_back(m_w);
                mptr = (m_w + 1) % N;
            end
            exp_busy = (mtags.size() != 0) || (exp_rv != 4'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; req_valid = '0; force_rdy = 1'b0; core_stall = 1'b0; fp_rfd = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [31:0] one_to_four [4] = '{32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] exp_data [4]    = '{32'h4000_0000, 32'h4080_0000, 32'h40c0_0000, 32'h4100_0000};
    logic [3:0]  exp_grant [5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] got_data[$];
    logic [3:0]  got_tag[$];
    int          grants;
    logic        seen_resp;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        settle();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_fp_a", fp_a, 32'h0);
        check("rst_fp_nd", 32'(fp_nd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err_orphan), 32'h0);

        // Single request from requester 2.
        step();
        set_req(2, 32'h3f80_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        settle();
        check("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        settle();
        check("single_nd", 32'(fp_nd), 32'h1);
        check("single_fp_a", fp_a, 32'h3f80_0000);
        check("single_fp_b", fp_b, 32'h4000_0000);
        repeat (7) step();
        settle();
        check("single_resp_valid", 32'(resp_valid), 32'h4);
        check("single_resp_data", resp_data, 32'h4000_0000);
        step();
        settle();
        check("single_resp_gone", 32'(resp_valid), 32'h0);

        // All four continuously valid: rotation and in-order return.
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, one_to_four[k], 32'h4000_0000);
        req_valid = 4'hf;
        for (int g = 0; g < 5; g++) begin
            settle();
            check("rr_grant", 32'(req_ready), 32'(exp_grant[g]));
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (resp_valid != 4'b0) begin
                got_data.push_back(resp_data);
                got_tag.push_back(resp_valid);
            end
            step();
        end
        check("rr_resp_count", 32'(got_data.size()), 32'd5);
        for (int k = 0; k < 4; k++) begin
            if (k < got_data.size()) begin
                check("rr_resp_data", got_data[k], exp_data[k]);
                check("rr_resp_tag", 32'(got_tag[k]), 32'(exp_grant[k]));
            end else begin
                check("rr_resp_missing", 32'(k), 32'hffff_ffff);
            end
        end

        // Core stalls: exactly MAX_OUT grants, then one slot frees a cycle after fp_rdy.
        do_reset();
        core_stall = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, one_to_four[k], 32'h4000_0000);
        req_valid = 4'hf;
        grants = 0;
        for (int c = 0; c < 14; c++) begin
            settle();
            if (req_ready != 4'b0) grants++;
            step();
        end
        check("full_grants", 32'(grants), 32'd8);
        settle();
        check("full_no_ready", 32'(req_ready), 32'h0);
        step();
        core_stall = 1'b0;
        settle();
        check("full_return_no_bypass", 32'(req_ready), 32'h0);
        step();
        settle();
        check("full_regrant", 32'(req_ready != 4'b0), 32'h1);
        step();
        req_valid = '0;
        repeat (30) step();
        settle();
        check("full_drained_busy", 32'(busy), 32'h0);

        // fp_rfd low blocks grants and freezes operands.
        do_reset();
        fp_rfd = 1'b0;
        set_req(1, 32'h4040_0000, 32'h4040_0000);
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("rfd_no_ready", 32'(req_ready), 32'h0);
            check("rfd_no_nd", 32'(fp_nd), 32'h0);
            check("rfd_fp_a_hold", fp_a, 32'h0);
            step();
        end
        fp_rfd = 1'b1;
        settle();
        check("rfd_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        settle();
        check("rfd_nd", 32'(fp_nd), 32'h1);
        check("rfd_fp_a", fp_a, 32'h4040_0000);
        repeat (10) step();

        // Orphan result with nothing in flight.
        do_reset();
        force_rdy = 1'b1;
        step();
        force_rdy = 1'b0;
        settle();
        check("orphan_set", 32'(err_orphan), 32'h1);
        check("orphan_no_resp", 32'(resp_valid), 32'h0);
        repeat (3) step();
        settle();
        check("orphan_sticky", 32'(err_orphan), 32'h1);
        do_reset();
        settle();
        check("orphan_cleared", 32'(err_orphan), 32'h0);

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) set_req(k, one_to_four[k], 32'h4000_0000);
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_resp", 32'(resp_valid), 32'h0);
        check("midrst_nd", 32'(fp_nd), 32'h0);
        check("midrst_fp_a", fp_a, 32'h0);
        check("midrst_fp_b", fp_b, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_err", 32'(err_orphan), 32'h0);
        seen_resp = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            settle();
            if (resp_valid != 4'b0) seen_resp = 1'b1;
        end
        check("midrst_orphans", 32'(err_orphan), 32'h1);
        check("midrst_no_resp", 32'(seen_resp), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
